calc_mc_core: RTL and testbench
===============================

# calc_mc_core

Parametrised multi-channel calculator core, the successor to the fixed four-port calculator. It accepts two-cycle command/operand requests on NUM_CH independent channels and buffers each channel in its own FIFO. A round-robin arbiter dispatches queued operations into one shared pipelined ALU, and each result returns on the originating channel's response port. It sits between the request agents and the bus interface, and adds buffering, back-pressure and width/channel scaling.

## Interface
- NUM_CH, 4: number of request channels (1..16).
- DATA_W, 32: operand/result width (≥8).
- DEPTH, 4: per-channel FIFO entries, power of two, ≥2.
- c_clk  in  1  single clock; all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_cmd_in  in  NUM_CH*4  per-channel command; channel i = [i*4 +: 4].
- req_data_in  in  NUM_CH*DATA_W  per-channel operand; channel i = [i*DATA_W +: DATA_W].
- ch_ready  out  NUM_CH  channel i may start a command this cycle.
- out_resp  out  NUM_CH*2  per-channel response: 0 none, 1 success, 2 overflow/underflow/invalid; 3 never driven.
- out_data  out  NUM_CH*DATA_W  per-channel result, valid only while out_resp≠0, else 0.

## Operation
- Commands: 0 no-op, 1 add, 2 subtract, 5 shift left, 6 shift right. Command 5/6 availability depends on configuration (see Configuration). All other codes are invalid.
- Channel FSM, IDLE→OPND→IDLE:
  - In IDLE with ch_ready=1, a cmd≠0 captures cmd and operand1, then the FSM moves to OPND.
  - In OPND, the next cycle's data is operand2; req_cmd_in is ignored. The {cmd, op1, op2} entry is pushed to the FIFO, and the FSM returns to IDLE.
- ch_ready[i] = IDLE and (fifo_count < DEPTH), evaluated from registers. A command presented while ch_ready=0 is silently dropped: no entry, no response.
- Invalid commands are queued like valid ones and respond 2, preserving per-channel ordering.
- Arbiter:
  - Round-robin over non-empty FIFOs, one grant per cycle.
  - The pointer moves to grantee+1 mod NUM_CH.
  - On the same cycle, a push to and a pop from one FIFO leave the count unchanged.
- ALU rules, all unsigned DATA_W:
  - add: carry out gives resp 2, data 0.
  - sub: op2 > op1 gives resp 2, data 0; op1 = op2 gives resp 1, data 0.
  - shifts use op2[$clog2(DATA_W)-1:0]; upper bits are ignored; shifts never error.
- Response: drives the granted channel's out_resp/out_data for exactly one cycle; all other channels read 0 that cycle. Responses are in order within each channel.

## Timing
- Cycle T: command plus op1. T+1: op2, FIFO push at end of T+1. T+2: arbitrate and load dispatch register. T+3: ALU evaluation, result registered. T+4: response visible.
- Uncontended latency is 4 cycles from the command cycle. Each cycle of arbitration wait adds 1.
- Per-channel issue rate is at most one command per 2 cycles. Aggregate throughput is one result per cycle.
- Reset, asserted at any time:
  - FIFOs flushed, FSMs to IDLE, pipeline cleared, arbiter pointer to channel 0.
  - out_resp=0, out_data=0, ch_ready=all 1 after release.
  - In-flight operations are lost with no response.
- Reset release is synchronised internally. The first command is accepted in the cycle after reset_n is sampled high.

## Configuration
- CALC_SHIFT_EN defined: commands 5/6 are executed.
- CALC_SHIFT_EN undefined: 5/6 are treated as invalid (resp 2, data 0), and no shifter is synthesised.

## Structure
- Package calc_pkg:
  - command code constants (CMD_NOP, CMD_ADD, CMD_SUB, CMD_SHL, CMD_SHR)
  - response constants (RESP_NONE, RESP_OK, RESP_ERR)
  - typedef for a queue entry {cmd, op1, op2} parametrised by DATA_W
- Sub-module calc_ch_frontend: channel FSM plus FIFO plus ch_ready, instantiated NUM_CH times via generate.
- Arbiter and ALU stay in calc_mc_core.

## Test plan
- Reset: hold reset_n low 4 cycles, assert mid-operation -> all out_resp/out_data 0, ch_ready=4'b1111, no stale response after release.
- Ch0 add 0x1 + 0x1FFF_FFFF at T -> at T+4 out_resp ch0=1, data 0x2000_0000; other channels 0.
- Errors: ch1 add 0xFFFF_FFFF + 0x1 -> resp 2, data 0; ch2 sub 0x1 − 0xF -> resp 2; ch3 cmd 3 and cmd 4 -> resp 2 each.
- Contention: all four channels add i+i at the same T -> responses at T+4..T+7 on ch0..ch3 in turn, data 0, 2, 4, 6.
- Back-pressure: all channels issue back-to-back for 40 cycles -> ch_ready drops; commands offered with ch_ready=0 get no response; response count equals accepted count, in order per channel.
- Shifts: ch0 cmd 5, op1 0x1, op2 0x24 -> with CALC_SHIFT_EN, resp 1, data 0x10; cmd 6, op1 0x80, op2 3 -> 0x10; without the macro, both resp 2, data 0.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared command and response encodings for the multi-channel calculator.
// Queue entries are declared next to their storage, sized by the user's DATA_W.
package calc_pkg;

  localparam int unsigned CMD_W  = 4;
  localparam int unsigned RESP_W = 2;

  typedef logic [CMD_W-1:0]  cmd_t;
  typedef logic [RESP_W-1:0] resp_t;

  localparam cmd_t CMD_NOP = 4'd0;
  localparam cmd_t CMD_ADD = 4'd1;
  localparam cmd_t CMD_SUB = 4'd2;
  localparam cmd_t CMD_SHL = 4'd5;
  localparam cmd_t CMD_SHR = 4'd6;

  localparam resp_t RESP_NONE = 2'd0;
  localparam resp_t RESP_OK   = 2'd1;
  localparam resp_t RESP_ERR  = 2'd2;

endpackage

// File: rtl/calc_ch_frontend.sv
// Per-channel request front end: two-cycle command/operand capture feeding a FIFO.
// ready is a pure function of registered state.
module calc_ch_frontend
  import calc_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              c_clk,
  input  logic              reset_n,
  input  logic              run,
  input  cmd_t              req_cmd,
  input  logic [DATA_W-1:0] req_data,
  input  logic              pop,
  output logic              ready,
  output logic              empty,
  output cmd_t              head_cmd,
  output logic [DATA_W-1:0] head_op1,
  output logic [DATA_W-1:0] head_op2
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef struct packed {
    cmd_t              cmd;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
  } entry_t;

  typedef enum logic {StIdle, StOpnd} state_e;

  state_e            state_q, state_d;
  cmd_t              cmd_q, cmd_d;
  logic [DATA_W-1:0] op1_q, op1_d;
  entry_t            mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q, cnt_d;
  logic              push;

  // DEPTH is a power of two, so the count is full exactly when its top bit is set.
  assign ready    = run && (state_q == StIdle) && !cnt_q[AW];
  assign empty    = (cnt_q == '0);
  assign push     = (state_q == StOpnd);
  assign head_cmd = mem_q[rd_ptr_q].cmd;
  assign head_op1 = mem_q[rd_ptr_q].op1;
  assign head_op2 = mem_q[rd_ptr_q].op2;

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    case (state_q)
      StIdle: begin
        if (ready && (req_cmd != CMD_NOP)) begin
          state_d = StOpnd;
          cmd_d   = req_cmd;
          op1_d   = req_data;
        end
      end
      StOpnd: state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      cmd_q    <= CMD_NOP;
      op1_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      cnt_q   <= cnt_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage needs no reset: the pointers and count define which entries are live.
  always_ff @(posedge c_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{cmd: cmd_q, op1: op1_q, op2: req_data};
    end
  end

endmodule

// File: rtl/calc_mc_core.sv
// Multi-channel calculator core: per-channel front ends, round-robin arbiter, shared ALU.
// Define CALC_SHIFT_EN to execute shift commands; otherwise they respond as invalid.
module calc_mc_core
  import calc_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                     c_clk,
  input  logic                     reset_n,
  input  logic [NUM_CH*CMD_W-1:0]  req_cmd_in,
  input  logic [NUM_CH*DATA_W-1:0] req_data_in,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [NUM_CH*RESP_W-1:0] out_resp,
  output logic [NUM_CH*DATA_W-1:0] out_data
);

  localparam int unsigned PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);
`ifdef CALC_SHIFT_EN
  localparam int unsigned SH_W = $clog2(DATA_W);
`endif

  logic              run_q;
  logic [NUM_CH-1:0] empty, pop;
  cmd_t              head_cmd [NUM_CH];
  logic [DATA_W-1:0] head_op1 [NUM_CH];
  logic [DATA_W-1:0] head_op2 [NUM_CH];

  logic              gnt_vld;
  logic [PTR_W-1:0]  gnt_idx, cand, ptr_q, ptr_d;

  logic              disp_vld_q;
  logic [PTR_W-1:0]  disp_ch_q;
  cmd_t              disp_cmd_q;
  logic [DATA_W-1:0] disp_op1_q, disp_op2_q;

  logic [DATA_W:0]   sum;
  resp_t             alu_resp;
  logic [DATA_W-1:0] alu_data;

  logic              res_vld_q;
  logic [PTR_W-1:0]  res_ch_q;
  resp_t             res_resp_q;
  logic [DATA_W-1:0] res_data_q;

  // Release of reset_n is retimed so no command is taken on the release edge itself.
  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    calc_ch_frontend #(
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
    ) u_frontend (
      .c_clk   (c_clk),
      .reset_n (reset_n),
      .run     (run_q),
      .req_cmd (req_cmd_in[i*CMD_W +: CMD_W]),
      .req_data(req_data_in[i*DATA_W +: DATA_W]),
      .pop     (pop[i]),
      .ready   (ch_ready[i]),
      .empty   (empty[i]),
      .head_cmd(head_cmd[i]),
      .head_op1(head_op1[i]),
      .head_op2(head_op2[i])
    );
  end

  // Scan downwards so the non-empty channel closest after the pointer wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(ptr_q) + k) % NUM_CH);
      if (!empty[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    pop   = '0;
    ptr_d = ptr_q;
    if (gnt_vld) begin
      pop[gnt_idx] = 1'b1;
      ptr_d        = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    alu_resp = RESP_ERR;
    alu_data = '0;
    sum      = {1'b0, disp_op1_q} + {1'b0, disp_op2_q};
    case (disp_cmd_q)
      CMD_ADD: begin
        if (!sum[DATA_W]) begin
          alu_resp = RESP_OK;
          alu_data = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (disp_op2_q <= disp_op1_q) begin
          alu_resp = RESP_OK;
          alu_data = disp_op1_q - disp_op2_q;
        end
      end
      CMD_SHL: begin
`ifdef CALC_SHIFT_EN
        alu_resp = RESP_OK;
        alu_data = disp_op1_q << disp_op2_q[SH_W-1:0];
`endif
      end
      CMD_SHR: begin
`ifdef CALC_SHIFT_EN
        alu_resp = RESP_OK;
        alu_data = disp_op1_q >> disp_op2_q[SH_W-1:0];
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge c_clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q      <= '0;
      disp_vld_q <= 1'b0;
      disp_ch_q  <= '0;
      disp_cmd_q <= CMD_NOP;
      disp_op1_q <= '0;
      disp_op2_q <= '0;
      res_vld_q  <= 1'b0;
      res_ch_q   <= '0;
      res_resp_q <= RESP_NONE;
      res_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      disp_vld_q <= gnt_vld;
      if (gnt_vld) begin
        disp_ch_q  <= gnt_idx;
        disp_cmd_q <= head_cmd[gnt_idx];
        disp_op1_q <= head_op1[gnt_idx];
        disp_op2_q <= head_op2[gnt_idx];
      end
      res_vld_q  <= disp_vld_q;
      res_ch_q   <= disp_ch_q;
      res_resp_q <= alu_resp;
      res_data_q <= alu_data;
    end
  end

  always_comb begin
    out_resp = {NUM_CH{RESP_NONE}};
    out_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (res_vld_q && (res_ch_q == PTR_W'(i))) begin
        out_resp[i*RESP_W +: RESP_W] = res_resp_q;
        out_data[i*DATA_W +: DATA_W] = res_data_q;
      end
    end
  end

endmodule

// File: tb/tb_calc_mc_core.sv
// Self-checking bench for calc_mc_core: per-channel scoreboard queues fed by the
// stimulus driver, drained by an independent output monitor.
module tb_calc_mc_core;

  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 32;
  localparam int unsigned DEP = 4;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    longint      cyc;
  } exp_t;

  logic              c_clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NCH*4-1:0]  req_cmd_in = '0;
  logic [NCH*DW-1:0] req_data_in = '0;
  logic [NCH-1:0]    ch_ready;
  logic [NCH*2-1:0]  out_resp;
  logic [NCH*DW-1:0] out_data;

  calc_mc_core #(
    .NUM_CH(NCH),
    .DATA_W(DW),
    .DEPTH (DEP)
  ) dut (
    .c_clk      (c_clk),
    .reset_n    (reset_n),
    .req_cmd_in (req_cmd_in),
    .req_data_in(req_data_in),
    .ch_ready   (ch_ready),
    .out_resp   (out_resp),
    .out_data   (out_data)
  );

  always #5 c_clk = ~c_clk;

  longint cyc = 0;
  always @(posedge c_clk) cyc <= cyc + 1;

  int   total = 0;
  int   bad = 0;
  int   n_acc = 0;
  int   n_seen = 0;
  int   n_drop = 0;
  bit   mon_en = 1'b0;
  exp_t sbq [NCH][$];

  logic [3:0]  scmd [NCH];
  logic [31:0] sa   [NCH];
  logic [31:0] sb   [NCH];
  int          sdly [NCH];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, got, want);
    end
  endtask

  function automatic exp_t ref_calc(input logic [3:0] c, input logic [31:0] a,
                                    input logic [31:0] b);
    exp_t e;
    logic [63:0] wide;
    e.resp = 2'd2;
    e.data = '0;
    e.cyc  = -1;
    wide   = {32'd0, a} + {32'd0, b};
    case (c)
      4'd1: if (wide < 64'h1_0000_0000) begin e.resp = 2'd1; e.data = wide[31:0]; end
      4'd2: if (b <= a) begin e.resp = 2'd1; e.data = a - b; end
`ifdef CALC_SHIFT_EN
      4'd5: begin e.resp = 2'd1; e.data = a << (b % 32); end
      4'd6: begin e.resp = 2'd1; e.data = a >> (b % 32); end
`endif
      default: ;
    endcase
    return e;
  endfunction

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < NCH; i++) s += sbq[i].size();
    return s;
  endfunction

  // Monitor: every cycle, any channel with a response must match its queue head.
  logic [1:0]  m_r;
  logic [31:0] m_d;
  exp_t        m_e;
  int          m_n;
  always @(negedge c_clk) begin
    if (mon_en) begin
      m_n = 0;
      for (int i = 0; i < NCH; i++) begin
        m_r = out_resp[i*2 +: 2];
        m_d = out_data[i*DW +: DW];
        if (m_r == 2'd0) begin
          chk($sformatf("idle_data ch%0d", i), 64'(m_d), 64'd0);
        end else begin
          m_n++;
          if (sbq[i].size() == 0) begin
            chk($sformatf("unexpected_resp ch%0d", i), 64'(m_r), 64'd0);
          end else begin
            m_e = sbq[i].pop_front();
            n_seen++;
            chk($sformatf("resp ch%0d", i), 64'(m_r), 64'(m_e.resp));
            chk($sformatf("data ch%0d", i), 64'(m_d), 64'(m_e.data));
            if (m_e.cyc >= 0) chk($sformatf("latency ch%0d", i), 64'(cyc), 64'(m_e.cyc));
          end
        end
      end
      chk("multi_resp_cycle", 64'(m_n > 1), 64'd0);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge c_clk);
    #1;
  endtask

  // One two-cycle slot on all channels; entered and left at #1 after a rising edge.
  task automatic send_slot(input logic [NCH-1:0] mask, input bit timed, input bit noise);
    logic [NCH-1:0] rdy;
    logic [NCH-1:0] acc;
    longint t0;
    exp_t e;
    rdy = ch_ready;
    t0  = cyc;
    acc = '0;
    for (int i = 0; i < NCH; i++) begin
      req_cmd_in[i*4 +: 4]    = mask[i] ? scmd[i] : 4'd0;
      req_data_in[i*DW +: DW] = mask[i] ? sa[i] : $urandom;
      if (mask[i] && (scmd[i] != 4'd0)) begin
        if (timed) chk($sformatf("ready_idle ch%0d", i), 64'(rdy[i]), 64'd1);
        if (rdy[i]) begin
          e     = ref_calc(scmd[i], sa[i], sb[i]);
          e.cyc = timed ? (t0 + 4 + longint'(sdly[i])) : -1;
          sbq[i].push_back(e);
          n_acc++;
          acc[i] = 1'b1;
        end else begin
          n_drop++;
        end
      end
    end
    @(posedge c_clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (acc[i]) chk($sformatf("opnd_ready ch%0d", i), 64'(ch_ready[i]), 64'd0);
      // Commands offered during the operand cycle must be ignored.
      req_cmd_in[i*4 +: 4]    = (acc[i] && noise) ? 4'($urandom_range(1, 15)) : 4'd0;
      req_data_in[i*DW +: DW] = acc[i] ? sb[i] : $urandom;
    end
    @(posedge c_clk);
    #1;
    req_cmd_in = '0;
  endtask

  task automatic one(input int ch, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] b);
    for (int i = 0; i < NCH; i++) begin
      scmd[i] = 4'd0;
      sdly[i] = 0;
    end
    scmd[ch] = c;
    sa[ch]   = a;
    sb[ch]   = b;
    send_slot(NCH'(1 << ch), 1'b1, 1'b0);
  endtask

  function automatic logic [3:0] rand_cmd();
    case ($urandom_range(0, 9))
      0, 1, 2: return 4'd1;
      3, 4, 5: return 4'd2;
      6:       return 4'd5;
      7:       return 4'd6;
      8:       return 4'd3;
      default: return 4'($urandom_range(7, 15));
    endcase
  endfunction

  task automatic rand_slot(input logic [NCH-1:0] mask);
    for (int i = 0; i < NCH; i++) begin
      scmd[i] = rand_cmd();
      sa[i]   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
      sb[i]   = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
      sdly[i] = 0;
    end
    send_slot(mask, 1'b0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < NCH; i++) begin
      scmd[i] = '0; sa[i] = '0; sb[i] = '0; sdly[i] = 0;
    end
    // Power-on reset, held for four cycles.
    repeat (2) @(posedge c_clk);
    mon_en = 1'b1;
    repeat (2) @(posedge c_clk);
    #1;
    chk("rst_resp", 64'(out_resp), 64'd0);
    chk("rst_data", 64'(out_data != '0), 64'd0);
    reset_n = 1'b1;
    idle(1);
    chk("ready_after_rst", 64'(ch_ready), 64'hF);

    one(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF);
    one(1, 4'd1, 32'hFFFF_FFFF, 32'h0000_0001);
    one(2, 4'd2, 32'h0000_0001, 32'h0000_000F);
    one(2, 4'd2, 32'h0000_1234, 32'h0000_1234);
    one(3, 4'd3, 32'h0000_0010, 32'h0000_0020);
    one(3, 4'd4, 32'h0000_0010, 32'h0000_0020);
    one(0, 4'd5, 32'h0000_0001, 32'h0000_0024);
    one(0, 4'd6, 32'h0000_0080, 32'h0000_0003);
    idle(8);

    // Reset in the middle of traffic: queued work is lost without a response.
    for (int i = 0; i < NCH; i++) begin
      scmd[i] = 4'd1; sa[i] = 32'(i + 10); sb[i] = 32'(i); sdly[i] = 0;
    end
    send_slot(4'hF, 1'b0, 1'b0);
    #2;
    reset_n = 1'b0;
    for (int i = 0; i < NCH; i++) sbq[i].delete();
    n_acc  = 0;
    n_seen = 0;
    #1;
    chk("midrst_resp", 64'(out_resp), 64'd0);
    chk("midrst_data", 64'(out_data != '0), 64'd0);
    idle(4);
    reset_n = 1'b1;
    idle(1);
    chk("ready_after_midrst", 64'(ch_ready), 64'hF);
    idle(6);

    // Contention right after reset: the pointer starts at channel 0.
    for (int i = 0; i < NCH; i++) begin
      scmd[i] = 4'd1; sa[i] = 32'(i); sb[i] = 32'(i); sdly[i] = i;
    end
    send_slot(4'hF, 1'b1, 1'b0);
    idle(10);

    n_drop = 0;
    for (int s = 0; s < 20; s++) rand_slot(4'hF);
    chk("backpressure_drop", 64'(n_drop > 0), 64'd1);
    for (int s = 0; s < 15; s++) rand_slot(NCH'($urandom));

    for (int k = 0; k < 400 && pending() != 0; k++) @(posedge c_clk);
    idle(4);
    chk("drain_pending", 64'(pending()), 64'd0);
    chk("resp_count", 64'(n_seen), 64'(n_acc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
